dct_prefft_reod: RTL
====================

Name: dct_preFFT_reod

Overview:
- Input reorder stage of the forward DCT path: dct_preFFT_reod → FFT → post-FFT rotation.
- Takes a real sequence x(0..N-1) in natural order and emits v = [x(0),x(2),…,x(N-2), x(N-1),x(N-3),…,x(1)].
- This is the exact inverse of the IDCT post-IFFT reorder.
- Ping-pong RAM banks let a new frame be written while the previous frame is read out.

Parameters:
- wDataInOut, 16, width of real/imag samples.
- MAX_LOG2N, 11, log2 of largest supported frame; bank depth 2^MAX_LOG2N.

Ports:
- clk  in  1  clock
- rst_n_sync  in  1  asynchronous active-low reset
- sink_valid  in  1  input sample valid
- sink_ready  out  1  block can accept a sample
- sink_error  in  2  upstream error, ORed into frame error
- sink_sop  in  1  first sample of frame
- sink_eop  in  1  last sample of frame
- sink_real  in  wDataInOut  input real
- sink_imag  in  wDataInOut  input imag
- fftpts_in  in  12  frame length N, power of 2, 8..2^MAX_LOG2N
- source_valid  out  1  output sample valid
- source_ready  in  1  downstream accepts
- source_error  out  2  frame error flags
- source_sop  out  1  first output of frame
- source_eop  out  1  last output of frame
- source_real  out  wDataInOut  output real
- source_imag  out  wDataInOut  output imag
- fftpts_out  out  12  N latched for the frame currently on source

Behaviour:
- Transfers: sink on sink_valid&&sink_ready; source on source_valid&&source_ready. Ready latency 0.
- Reset (async assert, sync release): all outputs 0; sink_ready 0, rising the cycle after reset release. Banks empty, write pointer on bank 0. RAM contents are don't-care.
- Write side:
  - On sop: latch N from fftpts_in, index i=0, clear frame error.
  - Sample i is written to address i/2 if i is even, N-1-(i-1)/2 if i is odd.
  - Samples with valid but no sop while idle are dropped.
- Frame close:
  - eop at i=N-1: normal close.
  - eop at i<N-1: close; error bit0 set; unwritten addresses are output with stale data.
  - i reaches N-1 without eop: close; error bit1 set; subsequent words are dropped until the next sop.
  - sop mid-frame: close the current frame with bit0 set; the sop word starts a new frame in the other bank if it is free, else it is dropped.
- sink_error (any bit) ORs into frame error bit0.
- Bank state per bank: EMPTY → FILLING → FULL → DRAINING → EMPTY.
  - Close moves FILLING to FULL and toggles the write pointer.
  - sink_ready is high only while the write bank is EMPTY or FILLING.
- Read side:
  - Reads the FULL bank at addresses 0..N-1 sequentially using synchronous RAM (1-cycle read).
  - A 2-entry output skid buffer guarantees no loss or duplication under arbitrary source_ready.
  - source_sop accompanies address 0, source_eop address N-1. source_error and fftpts_out are constant across the frame.
  - The bank returns to EMPTY the cycle after its eop transfer.
- Latency: with source_ready held high, first output is valid exactly 3 cycles after the eop input transfer. The output then streams 1 word/cycle.
- Simultaneous close of one bank and drain finish of the other: both take effect; sink_ready stays high with no gap.
- Reset mid-frame: both frames are discarded and outputs return to reset values immediately.

Optional Feature:
- Macro DCT_REOD_IMAG_ZERO_EN.
- Defined: sink_imag is ignored and not stored; RAM width is wDataInOut; source_imag is driven 0.
- Undefined: imag is stored and reordered alongside real (RAM width 2*wDataInOut).

Test Plan:
- Reorder: N=8, real 0..7, source_ready=1 → real out 0,2,4,6,7,5,3,1; sop on first, eop on last, error 00; first valid 3 cycles after eop.
- Ping-pong throughput: three back-to-back N=16 frames, source_ready=1 → sink_ready never drops for frames 1–2. Frame 3 stalls until frame 1 drains; each output is a correct permutation.
- Backpressure: N=32, source_ready random 50% → 32 outputs in order, no duplicates or losses, sop/eop exactly once.
- Short frame: N=8, eop at i=5 → 8 outputs, source_error=01. Long frame (no eop by i=7, two extra words) → error=10, extras dropped, next frame correct.
- Length change: frame N=8 then N=2048 (ramp data) → fftpts_out 8 then 2048. The 2048 output equals evens ascending then odds descending.
- Reset mid-drain: assert rst_n_sync during output word 3 of N=16 → all outputs 0 immediately. After release, a new frame processes correctly with no stale output.

Source files
------------

// File: rtl/dct_prefft_reod_if.sv
// Framed streaming bus (valid/ready, sop/eop, error, frame length) used on
// both the sink and source sides of dct_prefft_reod.
interface dct_prefft_reod_if #(parameter int W = 16);
  logic         valid;
  logic         ready;
  logic [1:0]   error;
  logic         sop;
  logic         eop;
  logic [W-1:0] data_re;
  logic [W-1:0] data_im;
  logic [11:0]  fftpts;

  modport master (output valid, error, sop, eop, data_re, data_im, fftpts, input ready);
  modport slave  (input valid, error, sop, eop, data_re, data_im, fftpts, output ready);
endinterface

// File: rtl/dct_prefft_reod.sv
// DCT pre-FFT input reorder: x(0..N-1) -> [evens ascending, odds descending] via ping-pong banks.
// Build option: define DCT_REOD_IMAG_ZERO_EN to drop the imaginary path (source imag driven 0).
module dct_prefft_reod #(
  parameter int wDataInOut = 16,
  parameter int MAX_LOG2N  = 11
) (
  input  logic              clk,
  input  logic              rst_n_sync,
  dct_prefft_reod_if.slave  sink,
  dct_prefft_reod_if.master source
);
  localparam int W  = wDataInOut;
  localparam int AW = MAX_LOG2N;
`ifdef DCT_REOD_IMAG_ZERO_EN
  localparam int DW = W;
`else
  localparam int DW = 2 * W;
`endif

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [1:0]    err;
    logic [11:0]   n;
  } entry_t;

  bank_state_t bank_st_reg  [2];
  bank_state_t bank_st_next [2];
  logic [11:0] bank_n_reg   [2];
  logic [11:0] bank_n_next  [2];
  logic [1:0]  bank_err_reg [2];
  logic [1:0]  bank_err_next[2];

  logic        ready_en_reg;
  logic        wptr_reg, wptr_next;
  logic [11:0] wi_reg, wi_next, wn_reg, wn_next;
  logic [1:0]  werr_reg, werr_next;
  logic        dr_sel_reg, dr_sel_next;

  logic        sink_fire, start_ok, we, wbank;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [11:0] cur_i, cur_n;
  logic [1:0]  cur_err;
  logic        cur_last;

  logic        rd_busy_reg, rd_sel_reg, rd_bank_reg;
  logic [11:0] rd_addr_reg, rd_n_reg;
  logic [1:0]  rd_err_reg;
  logic        rd_start, rd_issue, rd_last;

  logic          q_vld_reg, q_sop_reg, q_eop_reg;
  logic [1:0]    q_err_reg;
  logic [11:0]   q_n_reg;
  logic [DW-1:0] q_data_reg;

  entry_t      skid_reg [2];
  entry_t      head;
  logic        fifo_wp_reg, fifo_rp_reg;
  logic [1:0]  fifo_cnt_reg;
  logic        pop;
  logic [2:0]  occ;

  logic [DW-1:0] mem [2**(AW+1)];

  assign sink.ready = ready_en_reg &&
                      (bank_st_reg[wptr_reg] == EMPTY || bank_st_reg[wptr_reg] == FILLING);
  assign sink_fire  = sink.valid && sink.ready;
`ifdef DCT_REOD_IMAG_ZERO_EN
  assign wdata = sink.data_re;
`else
  assign wdata = {sink.data_im, sink.data_re};
`endif

  assign head     = skid_reg[fifo_rp_reg];
  assign pop      = (fifo_cnt_reg != 2'd0) && source.ready;
  // Issue only if the word landing in the skid buffer two edges from now still fits.
  assign occ      = 3'(fifo_cnt_reg) + 3'(q_vld_reg) - 3'(pop);
  assign rd_issue = rd_busy_reg && (occ <= 3'd1);
  assign rd_start = !rd_busy_reg && (bank_st_reg[rd_sel_reg] == FULL);
  assign rd_last  = (rd_addr_reg == rd_n_reg - 12'd1);

  always_comb begin
    bank_st_next  = bank_st_reg;
    bank_n_next   = bank_n_reg;
    bank_err_next = bank_err_reg;
    wptr_next     = wptr_reg;
    wi_next       = wi_reg;
    wn_next       = wn_reg;
    werr_next     = werr_reg;
    dr_sel_next   = dr_sel_reg;
    we            = 1'b0;
    wbank         = wptr_reg;
    waddr         = '0;
    start_ok      = 1'b0;
    cur_i         = sink.sop ? 12'd0 : wi_reg;
    cur_n         = sink.sop ? sink.fftpts : wn_reg;
    cur_err       = (sink.sop ? 2'b00 : werr_reg) | {1'b0, |sink.error};
    cur_last      = (cur_i == cur_n - 12'd1);
    if (sink_fire) begin
      if (sink.sop) begin
        if (bank_st_reg[wptr_reg] == FILLING) begin
          // Mid-frame sop truncates the open frame; the new one goes to the other bank if free.
          bank_st_next[wptr_reg]  = FULL;
          bank_n_next[wptr_reg]   = wn_reg;
          bank_err_next[wptr_reg] = werr_reg | 2'b01;
          wbank                   = ~wptr_reg;
          wptr_next               = ~wptr_reg;
          start_ok                = (bank_st_reg[~wptr_reg] == EMPTY);
        end else begin
          start_ok = 1'b1;
        end
      end else begin
        start_ok = (bank_st_reg[wptr_reg] == FILLING);
      end
      if (start_ok) begin
        we    = 1'b1;
        waddr = cur_i[0] ? AW'(cur_n - 12'd1 - (cur_i >> 1)) : AW'(cur_i >> 1);
        if (sink.eop || cur_last) begin
          bank_st_next[wbank]  = FULL;
          bank_n_next[wbank]   = cur_n;
          bank_err_next[wbank] = cur_err | {cur_last && !sink.eop, sink.eop && !cur_last};
          wptr_next            = ~wbank;
        end else begin
          bank_st_next[wbank] = FILLING;
          wi_next             = cur_i + 12'd1;
          wn_next             = cur_n;
          werr_next           = cur_err;
        end
      end
    end
    if (rd_start)
      bank_st_next[rd_sel_reg] = DRAINING;
    if (pop && head.eop) begin
      bank_st_next[dr_sel_reg] = EMPTY;
      dr_sel_next              = ~dr_sel_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      for (int b = 0; b < 2; b++) begin
        bank_st_reg[b]  <= EMPTY;
        bank_n_reg[b]   <= '0;
        bank_err_reg[b] <= '0;
      end
      ready_en_reg <= 1'b0;
      wptr_reg     <= 1'b0;
      wi_reg       <= '0;
      wn_reg       <= '0;
      werr_reg     <= '0;
      dr_sel_reg   <= 1'b0;
    end else begin
      bank_st_reg  <= bank_st_next;
      bank_n_reg   <= bank_n_next;
      bank_err_reg <= bank_err_next;
      ready_en_reg <= 1'b1;
      wptr_reg     <= wptr_next;
      wi_reg       <= wi_next;
      wn_reg       <= wn_next;
      werr_reg     <= werr_next;
      dr_sel_reg   <= dr_sel_next;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[{wbank, waddr}] <= wdata;
    if (rd_issue)
      q_data_reg <= mem[{rd_bank_reg, rd_addr_reg[AW-1:0]}];
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rd_busy_reg <= 1'b0;
      rd_sel_reg  <= 1'b0;
      rd_bank_reg <= 1'b0;
      rd_addr_reg <= '0;
      rd_n_reg    <= '0;
      rd_err_reg  <= '0;
      q_vld_reg   <= 1'b0;
      q_sop_reg   <= 1'b0;
      q_eop_reg   <= 1'b0;
      q_err_reg   <= '0;
      q_n_reg     <= '0;
    end else begin
      if (rd_start) begin
        rd_busy_reg <= 1'b1;
        rd_addr_reg <= '0;
        rd_bank_reg <= rd_sel_reg;
        rd_sel_reg  <= ~rd_sel_reg;
        rd_n_reg    <= bank_n_reg[rd_sel_reg];
        rd_err_reg  <= bank_err_reg[rd_sel_reg];
      end else if (rd_issue) begin
        rd_addr_reg <= rd_addr_reg + 12'd1;
        if (rd_last)
          rd_busy_reg <= 1'b0;
      end
      q_vld_reg <= rd_issue;
      q_sop_reg <= (rd_addr_reg == 12'd0);
      q_eop_reg <= rd_last;
      q_err_reg <= rd_err_reg;
      q_n_reg   <= rd_n_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      skid_reg[0]  <= '0;
      skid_reg[1]  <= '0;
      fifo_wp_reg  <= 1'b0;
      fifo_rp_reg  <= 1'b0;
      fifo_cnt_reg <= '0;
    end else begin
      if (q_vld_reg) begin
        skid_reg[fifo_wp_reg] <= '{data: q_data_reg, sop: q_sop_reg, eop: q_eop_reg,
                                   err: q_err_reg, n: q_n_reg};
        fifo_wp_reg <= ~fifo_wp_reg;
      end
      if (pop)
        fifo_rp_reg <= ~fifo_rp_reg;
      fifo_cnt_reg <= fifo_cnt_reg + 2'(q_vld_reg) - 2'(pop);
    end
  end

  assign source.valid   = (fifo_cnt_reg != 2'd0);
  assign source.sop     = source.valid && head.sop;
  assign source.eop     = source.valid && head.eop;
  assign source.error   = head.err;
  assign source.fftpts  = head.n;
  assign source.data_re = head.data[W-1:0];
`ifdef DCT_REOD_IMAG_ZERO_EN
  assign source.data_im = '0;
`else
  assign source.data_im = head.data[DW-1:W];
`endif
endmodule
